// File: rtl/backward_pkg.sv
// Shared constants and FSM state encoding for the distance-transform backward pass.
// The image is square, IMG_W x IMG_W, stored row-major in the result memory.
package dt_pkg;
    localparam int IMG_W  = 128;
    localparam int ADDR_W = 14;

    // The pass visits row 126 / col 126 down to row 1 / col 1.
    localparam int FIRST_ADDR = (IMG_W - 2) * IMG_W + (IMG_W - 2);
    localparam int LAST_ADDR  = IMG_W + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_CUR = 3'd1,
        RD_E   = 3'd2,
        RD_SW  = 3'd3,
        RD_S   = 3'd4,
        RD_SE  = 3'd5,
        WR     = 3'd6,
        DONE   = 3'd7
    } bk_state_t;
endpackage

// File: rtl/backward_if.sv
// Control and result-memory port bundle of the backward pass.
// slave is the pass engine; master is the controller plus memory side.
interface backward_if;
    import dt_pkg::*;

    logic              back_start;
    logic [7:0]        res_di;
    logic [ADDR_W-1:0] res_addr_back;
    logic              res_rd;
    logic              res_wr;
    logic [7:0]        res_do_back;
    logic              back_busy;
    logic              back_done;

    modport slave (
        input  back_start, res_di,
        output res_addr_back, res_rd, res_wr, res_do_back, back_busy, back_done
    );

    modport master (
        output back_start, res_di,
        input  res_addr_back, res_rd, res_wr, res_do_back, back_busy, back_done
    );
endinterface

// File: rtl/backward_min4_inc.sv
// Combinational min of four 8-bit neighbours plus one, zero latency, no backpressure.
// BACKWARD_SATURATE_EN: clamp the increment at 8'hFF; otherwise wrap to 8 bits.
module min4_inc (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [7:0] c,
    input  logic [7:0] d,
    output logic [7:0] y
);
    logic [7:0] m_ab;
    logic [7:0] m_cd;
    logic [7:0] m_all;
    logic [8:0] sum;

    assign m_ab  = (a < b) ? a : b;
    assign m_cd  = (c < d) ? c : d;
    assign m_all = (m_ab < m_cd) ? m_ab : m_cd;
    assign sum   = {1'b0, m_all} + 9'd1;

`ifdef BACKWARD_SATURATE_EN
    assign y = sum[8] ? 8'hFF : sum[7:0];
`else
    // Wrapping keeps the arithmetic identical to the forward pass.
    logic unused_carry;
    assign unused_carry = sum[8];
    assign y = sum[7:0];
`endif
endmodule

// File: rtl/backward.sv
// Backward distance-transform pass over the result memory: 6 cycles per object pixel, 1 per skip.
// No backpressure; memory reads are combinational. Option macro: BACKWARD_SATURATE_EN (in min4_inc).
module backward #(
    parameter int IMG_W = dt_pkg::IMG_W
) (
    input logic       clk,
    input logic       reset,
    backward_if.slave bus
);
    import dt_pkg::bk_state_t, dt_pkg::IDLE, dt_pkg::RD_CUR, dt_pkg::RD_E, dt_pkg::RD_SW;
    import dt_pkg::RD_S, dt_pkg::RD_SE, dt_pkg::WR, dt_pkg::DONE;

    localparam int              AW     = dt_pkg::ADDR_W;
    localparam logic [AW-1:0]   FIRST  = AW'((IMG_W - 2) * IMG_W + (IMG_W - 2));
    localparam logic [AW-1:0]   LAST   = AW'(IMG_W + 1);
    localparam logic [AW-1:0]   OFS_E  = AW'(1);
    localparam logic [AW-1:0]   OFS_SW = AW'(IMG_W - 1);
    localparam logic [AW-1:0]   OFS_S  = AW'(IMG_W);
    localparam logic [AW-1:0]   OFS_SE = AW'(IMG_W + 1);

    bk_state_t     state;
    logic [AW-1:0] cur;
    logic [7:0]    v_cur;
    logic [7:0]    v_e;
    logic [7:0]    v_sw;
    logic [7:0]    v_s;
    logic [7:0]    v_se;
    logic [AW-1:0] col;
    logic          skip;
    logic [7:0]    nb_inc;

    assign col  = cur % AW'(IMG_W);
    // Border columns and background pixels are left untouched.
    assign skip = (col == '0) || (col == AW'(IMG_W - 1)) || (bus.res_di == 8'd0);

    min4_inc u_min4_inc (
        .a (v_e),
        .b (v_sw),
        .c (v_s),
        .d (v_se),
        .y (nb_inc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cur   <= '0;
            v_cur <= 8'hFF;
            v_e   <= 8'hFF;
            v_sw  <= 8'hFF;
            v_s   <= 8'hFF;
            v_se  <= 8'hFF;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.back_start) begin
                        cur   <= FIRST;
                        state <= RD_CUR;
                    end
                end
                RD_CUR: begin
                    if (skip) begin
                        if (cur == LAST) state <= DONE;
                        else             cur   <= cur - AW'(1);
                    end else begin
                        v_cur <= bus.res_di;
                        state <= RD_E;
                    end
                end
                RD_E: begin
                    v_e   <= bus.res_di;
                    state <= RD_SW;
                end
                RD_SW: begin
                    v_sw  <= bus.res_di;
                    state <= RD_S;
                end
                RD_S: begin
                    v_s   <= bus.res_di;
                    state <= RD_SE;
                end
                RD_SE: begin
                    v_se  <= bus.res_di;
                    state <= WR;
                end
                WR: begin
                    if (cur == LAST) begin
                        state <= DONE;
                    end else begin
                        cur   <= cur - AW'(1);
                        state <= RD_CUR;
                    end
                end
                DONE: begin
                    if (!bus.back_start) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode only flopped state, so reset clears them asynchronously.
    always_comb begin
        bus.res_addr_back = '0;
        bus.res_rd        = 1'b0;
        bus.res_wr        = 1'b0;
        bus.res_do_back   = 8'd0;
        bus.back_busy     = 1'b0;
        bus.back_done     = 1'b0;
        case (state)
            RD_CUR: begin
                bus.res_addr_back = cur;
                bus.res_rd        = 1'b1;
                bus.back_busy     = 1'b1;
            end
            RD_E: begin
                bus.res_addr_back = cur + OFS_E;
                bus.res_rd        = 1'b1;
                bus.back_busy     = 1'b1;
            end
            RD_SW: begin
                bus.res_addr_back = cur + OFS_SW;
                bus.res_rd        = 1'b1;
                bus.back_busy     = 1'b1;
            end
            RD_S: begin
                bus.res_addr_back = cur + OFS_S;
                bus.res_rd        = 1'b1;
                bus.back_busy     = 1'b1;
            end
            RD_SE: begin
                bus.res_addr_back = cur + OFS_SE;
                bus.res_rd        = 1'b1;
                bus.back_busy     = 1'b1;
            end
            WR: begin
                bus.res_addr_back = cur;
                bus.res_wr        = 1'b1;
                bus.res_do_back   = (v_cur < nb_inc) ? v_cur : nb_inc;
                bus.back_busy     = 1'b1;
            end
            DONE: begin
                bus.back_done     = 1'b1;
            end
            default: ;
        endcase
    end
endmodule
